video_pattern_gen: RTL

- Programmable video source that produces VSYNC/HSYNC/DEN/8-bit DATA.
- Sits directly upstream of the blur/scaler IP and drives its I_VSYNC/I_HSYNC/I_DEN/I_DATA inputs for bring-up, BIST and regression.
- Timing and pattern select are quasi-static inputs, typically from SFRs. They are captured at every frame start, so mid-frame writes never tear a frame.

---
 rtl/video_pattern_gen.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// Programmable VSYNC/HSYNC/DEN/DATA test-pattern source.
// Optional frame counter and scrolling ramps: VIDEO_PATTERN_GEN_FRAME_CNT_EN.
module video_pattern_gen #(
  parameter int PARAM_WIDTH = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int CHECK_SHIFT = 3
) (
  input  logic                   I_CLK,
  input  logic                   I_RST,
  input  logic                   i_en,
  input  logic [1:0]             i_pattern,
  input  logic [DATA_WIDTH-1:0]  i_solid,
  input  logic [PARAM_WIDTH-1:0] i_hsw,
  input  logic [PARAM_WIDTH-1:0] i_hbp,
  input  logic [PARAM_WIDTH-1:0] i_hact,
  input  logic [PARAM_WIDTH-1:0] i_hfp,
  input  logic [PARAM_WIDTH-1:0] i_vsw,
  input  logic [PARAM_WIDTH-1:0] i_vbp,
  input  logic [PARAM_WIDTH-1:0] i_vact,
  input  logic [PARAM_WIDTH-1:0] i_vfp,
  output logic                   o_vsync,
  output logic                   o_hsync,
  output logic                   o_den,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_busy,
`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  output logic [15:0]            o_frame_cnt,
`endif
  output logic                   o_cfg_err
);

  localparam int PW = PARAM_WIDTH;
  localparam int SW = PARAM_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] h_q, h_d;
  logic [PW-1:0] v_q, v_d;
  logic          err_q, err_d;
  logic          cap;

  logic [PW-1:0] hsw_q, ha0_q, ha1_q, hlast_q;
  logic [PW-1:0] vsw_q, va0_q, va1_q, vlast_q;
  logic [1:0]    pat_q;
  logic [DATA_WIDTH-1:0] solid_q;

  logic                  vsync_q, hsync_q, den_q, busy_q;
  logic [DATA_WIDTH-1:0] data_q;

  // Wide sums so an overflowing total is detected, not wrapped.
  logic [SW-1:0] ha0_w, ha1_w, htot_w;
  logic [SW-1:0] va0_w, va1_w, vtot_w;
  logic          legal_w;

  assign ha0_w  = SW'(i_hsw) + SW'(i_hbp);
  assign ha1_w  = ha0_w + SW'(i_hact);
  assign htot_w = ha1_w + SW'(i_hfp);
  assign va0_w  = SW'(i_vsw) + SW'(i_vbp);
  assign va1_w  = va0_w + SW'(i_vact);
  assign vtot_w = va1_w + SW'(i_vfp);

  assign legal_w = (|i_hsw) && (|i_hact) &&
                   (|i_vsw) && (|i_vact) &&
                   (htot_w[SW-1:PW] == 2'b00) &&
                   (vtot_w[SW-1:PW] == 2'b00);

  logic h_last, v_last, eof;

  assign h_last = (h_q == hlast_q);
  assign v_last = (v_q == vlast_q);
  assign eof    = h_last && v_last;

  // Next state, counter advance and capture decision.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    err_d   = err_q;
    cap     = 1'b0;
    unique case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (i_en) begin
          if (legal_w) begin
            cap     = 1'b1;
            err_d   = 1'b0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN, STOP: begin
        if (h_last) begin
          h_d = '0;
          v_d = v_last ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
        if (eof) begin
          if (state_q == RUN && i_en) begin
            if (legal_w) begin
              cap   = 1'b1;
              err_d = 1'b0;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            state_d = IDLE;
          end
        end else if (state_q == RUN && !i_en) begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        h_d     = '0;
        v_d     = '0;
      end
    endcase
  end

  // State, counters and sticky config error.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      err_q   <= err_d;
    end
  end

  // Frame-start capture of timing and pattern settings.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      hsw_q   <= '0;
      ha0_q   <= '0;
      ha1_q   <= '0;
      hlast_q <= '0;
      vsw_q   <= '0;
      va0_q   <= '0;
      va1_q   <= '0;
      vlast_q <= '0;
      pat_q   <= '0;
      solid_q <= '0;
    end else if (cap) begin
      hsw_q   <= i_hsw;
      ha0_q   <= PW'(ha0_w);
      ha1_q   <= PW'(ha1_w);
      hlast_q <= PW'(htot_w - 1'b1);
      vsw_q   <= i_vsw;
      va0_q   <= PW'(va0_w);
      va1_q   <= PW'(va1_w);
      vlast_q <= PW'(vtot_w - 1'b1);
      pat_q   <= i_pattern;
      solid_q <= i_solid;
    end
  end

  logic [DATA_WIDTH-1:0] ofs_w;

`ifdef VIDEO_PATTERN_GEN_FRAME_CNT_EN
  logic [15:0] fc_q;

  // Completed-frame counter; ticks on the last counter state.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      fc_q <= '0;
    end else if (state_q != IDLE && eof) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign ofs_w       = DATA_WIDTH'(fc_q);
  assign o_frame_cnt = fc_q;
`else
  assign ofs_w = '0;
`endif

  logic                  act_w, den_w;
  logic [DATA_WIDTH-1:0] x_w, y_w, pix_w;

  assign act_w = (state_q != IDLE);
  assign den_w = act_w &&
                 (h_q >= ha0_q) && (h_q < ha1_q) &&
                 (v_q >= va0_q) && (v_q < va1_q);
  assign x_w   = DATA_WIDTH'(h_q - ha0_q);
  assign y_w   = DATA_WIDTH'(v_q - va0_q);

  // Pixel value for the captured pattern.
  always_comb begin
    pix_w = '0;
    unique case (1'b1)
      pat_q == 2'd0: pix_w = solid_q;
      pat_q == 2'd1: pix_w = x_w + ofs_w;
      pat_q == 2'd2: pix_w = y_w + ofs_w;
      pat_q == 2'd3: pix_w = (x_w[CHECK_SHIFT] ^ y_w[CHECK_SHIFT]) ? '1 : '0;
      default:       pix_w = '0;
    endcase
  end

  // Output register stage, one cycle behind the counters.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
      den_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      vsync_q <= act_w && (v_q < vsw_q);
      hsync_q <= act_w && (h_q < hsw_q);
      den_q   <= den_w;
      data_q  <= den_w ? pix_w : '0;
      busy_q  <= (state_d != IDLE) || (state_q != IDLE);
    end
  end

  assign o_vsync   = vsync_q;
  assign o_hsync   = hsync_q;
  assign o_den     = den_q;
  assign o_data    = data_q;
  assign o_busy    = busy_q;
  assign o_cfg_err = err_q;

endmodule
